// File: rtl/pc_unit_pkg.sv
// pc_pkg: shared definitions for the fetch program counter.
//   pc_sel_e             - next-PC source selected by the priority mux
//   DEFAULT_RESET_VECTOR - PC loaded on reset unless overridden
//   DEFAULT_INSTR_BYTES  - sequential increment unless overridden
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEFAULT_INSTR_BYTES  = 4;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-stage control and PC outputs.
//   master (pipeline side): drives stall/redirect/call/ret, reads pc and RAS flags
//   slave  (pc_unit side):  reads the controls, drives pc, pc_plus and RAS flags
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;

  modport master (
    output stall, redirect_valid, redirect_target, call, ret,
    input  pc, pc_plus, ras_empty, ras_full, ras_overflow
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, call, ret,
    output pc, pc_plus, ras_empty, ras_full, ras_overflow
  );
endinterface

// File: rtl/pc_unit_return_stack.sv
// return_stack: circular return-address stack, state updated on falling clk.
//   clk, reset  - clock (negedge active), synchronous active-high reset
//   push        - top <= top+1, write push_data there; overwrites oldest when full
//   pop         - top <= top-1 (ignored when empty)
//   replace     - overwrite entry at top; count becomes 1 if it was 0
//   push_data   - value written by push/replace
//   top_data    - entry at top
//   count       - number of valid entries, saturating at RAS_DEPTH
//   empty/full  - count == 0 / count == RAS_DEPTH
//   overflow    - sticky, set by a push into a full stack
module return_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             replace,
  input  logic [WIDTH-1:0]                 push_data,
  output logic [WIDTH-1:0]                 top_data,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
  output logic                             empty,
  output logic                             full,
  output logic                             overflow
);
  localparam int unsigned AW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [AW-1:0]    top;
  logic [AW-1:0]    top_inc;

  assign top_inc  = top + AW'(1);
  assign top_data = mem[top];
  assign empty    = (count == '0);
  assign full     = (count == CW'(RAS_DEPTH));

  always_ff @(negedge clk) begin
    if (reset) begin
      top      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      top <= top_inc;
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      top   <= top - AW'(1);
      count <= count - CW'(1);
    end else if (replace && empty) begin
      count <= CW'(1);
    end
  end

  // Entries are not reset; count alone decides what is valid.
  always_ff @(negedge clk) begin
    if (!reset) begin
      if (push) begin
        mem[top_inc] <= push_data;
      end else if (replace) begin
        mem[top] <= push_data;
      end
    end
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with redirect, stall and RAS return prediction.
//   clk, reset - clock (state updates on falling edge), synchronous active-high reset
//   bus        - pc_unit_if slave: stall, redirect_valid/target, call, ret in;
//                pc, pc_plus, ras_empty, ras_full, ras_overflow out
// Next-PC priority: reset > redirect > stall > ret (RAS non-empty) > sequential.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int unsigned      INSTR_BYTES  = DEFAULT_INSTR_BYTES,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  pc_unit_if.slave   bus
);
  localparam int unsigned      CW         = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(INSTR_BYTES) - WIDTH'(1));

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_count;
  logic             accept;
  logic             do_call;
  logic             do_ret;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;
  pc_sel_e          sel;

  assign pc_plus = pc_q + WIDTH'(INSTR_BYTES);

  // call/ret only take effect when the PC is actually advancing this edge.
  assign accept      = !reset && !bus.redirect_valid && !bus.stall;
  assign do_call     = accept && bus.call;
  assign do_ret      = accept && bus.ret;
  assign ras_push    = do_call && !do_ret;
  assign ras_pop     = do_ret && !do_call;
  assign ras_replace = do_call && do_ret;

  always_comb begin
    sel = SEL_SEQ;
    if (reset) begin
      sel = SEL_RESET;
    end else if (bus.redirect_valid) begin
      sel = SEL_REDIRECT;
    end else if (bus.stall) begin
      sel = SEL_HOLD;
    end else if (bus.ret && ras_count != '0) begin
      sel = SEL_RAS;
    end
  end

  always_comb begin
    pc_d = pc_plus;
    unique case (sel)
      SEL_RESET:    pc_d = RESET_VECTOR;
      SEL_REDIRECT: pc_d = bus.redirect_target & ALIGN_MASK;
      SEL_HOLD:     pc_d = pc_q;
      SEL_RAS:      pc_d = ras_top;
      default:      pc_d = pc_plus;
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  return_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .replace   (ras_replace),
    .push_data (pc_plus),
    .top_data  (ras_top),
    .count     (ras_count),
    .empty     (bus.ras_empty),
    .full      (bus.ras_full),
    .overflow  (bus.ras_overflow)
  );

  assign bus.pc      = pc_q;
  assign bus.pc_plus = pc_plus;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  logic clk;
  logic reset;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000),
    .INSTR_BYTES  (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [31:0] pc;
    bit          fchk;
    bit          e;
    bit          f;
    bit          o;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Drive one cycle's inputs on the rising edge and queue the state expected
  // after the following falling edge.
  task automatic step(input string nm, input bit r, input bit st, input bit rv,
                      input logic [31:0] rt, input bit c, input bit rn,
                      input logic [31:0] ep, input bit fc, input bit e,
                      input bit f, input bit o);
    exp_t x;
    @(posedge clk);
    reset               = r;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.call            = c;
    bus.ret             = rn;
    x.name = nm; x.pc = ep; x.fchk = fc; x.e = e; x.f = f; x.o = o;
    exp_q.push_back(x);
  endtask

  // Monitor: every falling edge produces a new PC; compare against the queue.
  initial begin
    exp_t x;
    logic [31:0] ep_plus;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        ep_plus = x.pc + 32'd4;
        checks++;
        if (bus.pc !== x.pc) begin
          errors++;
          $display("FAIL %s pc: got %h expected %h", x.name, bus.pc, x.pc);
        end
        checks++;
        if (bus.pc_plus !== ep_plus) begin
          errors++;
          $display("FAIL %s pc_plus: got %h expected %h", x.name, bus.pc_plus, ep_plus);
        end
        if (x.fchk) begin
          checks++;
          if ({bus.ras_empty, bus.ras_full, bus.ras_overflow} !== {x.e, x.f, x.o}) begin
            errors++;
            $display("FAIL %s flags(empty,full,ovf): got %b%b%b expected %b%b%b",
                     x.name, bus.ras_empty, bus.ras_full, bus.ras_overflow, x.e, x.f, x.o);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] RET_PC [5] = '{32'h14, 32'h10, 32'hC, 32'h8, 32'hC};

  initial begin
    reset = 1'b0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    bus.call = 1'b0; bus.ret = 1'b0;

    // reset and free run
    step("reset",      1,0,0,32'h0,0,0, 32'h0,  1,1,0,0);
    step("seq1",       0,0,0,32'h0,0,0, 32'h4,  1,1,0,0);
    step("seq2",       0,0,0,32'h0,0,0, 32'h8,  0,0,0,0);
    step("seq3",       0,0,0,32'h0,0,0, 32'hC,  0,0,0,0);
    // redirect alignment and stall
    step("redir_align",0,0,1,32'hECAB,0,0, 32'hECA8, 0,0,0,0);
    step("stall1",     0,1,0,32'h0,0,0, 32'hECA8, 0,0,0,0);
    step("stall_call", 0,1,0,32'h0,1,0, 32'hECA8, 1,1,0,0);
    step("stall_ret",  0,1,0,32'h0,0,1, 32'hECA8, 1,1,0,0);
    step("stall_redir",0,1,1,32'h100,0,0, 32'h100, 0,0,0,0);
    // call / return
    step("to_20",      0,0,1,32'h20,0,0, 32'h20, 0,0,0,0);
    step("call_redir", 0,0,1,32'h400,1,0, 32'h400, 1,1,0,0);
    step("to_20b",     0,0,1,32'h20,0,0, 32'h20, 1,1,0,0);
    step("call",       0,0,0,32'h0,1,0, 32'h24, 1,0,0,0);
    step("to_400",     0,0,1,32'h400,0,0, 32'h400, 1,0,0,0);
    step("ret",        0,0,0,32'h0,0,1, 32'h24, 1,1,0,0);
    // overflow
    step("to_0",       0,0,1,32'h0,0,0, 32'h0, 0,0,0,0);
    for (int i = 0; i < 5; i++)
      step("call_ovf", 0,0,0,32'h0,1,0, 32'((i + 1) * 4), 1,0,(i >= 3),(i == 4));
    for (int i = 0; i < 5; i++)
      step("ret_ovf",  0,0,0,32'h0,0,1, RET_PC[i], 1,(i >= 3),0,1);
    // boundaries
    step("to_40",      0,0,1,32'h40,0,0, 32'h40, 0,0,0,0);
    step("ret_empty",  0,0,0,32'h0,0,1, 32'h44, 1,1,0,1);
    step("to_20c",     0,0,1,32'h20,0,0, 32'h20, 0,0,0,0);
    step("call2",      0,0,0,32'h0,1,0, 32'h24, 1,0,0,1);
    step("to_80",      0,0,1,32'h80,0,0, 32'h80, 0,0,0,0);
    step("call_ret",   0,0,0,32'h0,1,1, 32'h24, 1,0,0,1);
    step("to_200",     0,0,1,32'h200,0,0, 32'h200, 0,0,0,0);
    step("ret_newtop", 0,0,0,32'h0,0,1, 32'h84, 1,1,0,1);
    step("to_wrap",    0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 0,0,0,0);
    step("wrap",       0,0,0,32'h0,0,0, 32'h0, 0,0,0,0);
    // reset mid-operation with 3 entries
    step("fill1",      0,0,0,32'h0,1,0, 32'h4, 0,0,0,0);
    step("fill2",      0,0,0,32'h0,1,0, 32'h8, 0,0,0,0);
    step("fill3",      0,0,0,32'h0,1,0, 32'hC, 1,0,0,1);
    step("reset_mid",  1,1,1,32'h500,1,1, 32'h0, 1,1,0,0);
    step("post_rst",   0,0,0,32'h0,0,0, 32'h4, 1,1,0,0);
    step("ret_postrst",0,0,0,32'h0,0,1, 32'h8, 1,1,0,0);

    @(posedge clk);
    bus.ret = 1'b0; bus.call = 1'b0;
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
